// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and decode helpers for the ALU pipeline.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_SLL  = 3'b100,
        OP_SRA  = 3'b101,
        OP_ROR  = 3'b110,
        OP_ILL  = 3'b111
    } opcode_e;

    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    function automatic logic is_arith(opcode_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result valid-ready bundle of the ALU pipeline; master drives operands, slave is the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] ALU_In1;
    logic [WIDTH-1:0] ALU_In2;
    logic [2:0]       Opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_Out;
    logic             Error;
    logic [2:0]       Flags;

    modport master (
        output in_valid, ALU_In1, ALU_In2, Opcode, out_ready,
        input  in_ready, out_valid, ALU_Out, Error, Flags
    );

    modport slave (
        input  in_valid, ALU_In1, ALU_In2, Opcode, out_ready,
        output in_ready, out_valid, ALU_Out, Error, Flags
    );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: add/sub with signed-overflow detect, logic ops, shifts, rotate.
// Defining ALU_SAT_EN clamps overflowing ADD/SUB results instead of wrapping.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  opcode_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             error
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] WIDTH_AMT = WIDTH[SHW:0];
`ifdef ALU_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic [SHW-1:0]   shamt;
    logic [SHW:0]     rot_back;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;

    assign shamt    = b[SHW-1:0];
    // An amount of 0 gives a left shift by WIDTH, which contributes nothing.
    assign rot_back = WIDTH_AMT - {1'b0, shamt};
    assign sum      = a + b;
    assign diff     = a - b;
    assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
    assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        result = '0;
        error  = 1'b0;
        case (op)
            OP_ADD:  begin result = sum;  error = add_ovf; end
            OP_SUB:  begin result = diff; error = sub_ovf; end
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~(a & b);
            OP_SLL:  result = a << shamt;
            OP_SRA:  result = $signed(a) >>> shamt;
            OP_ROR:  result = (a >> shamt) | (a << rot_back);
            default: error  = 1'b1;
        endcase
`ifdef ALU_SAT_EN
        // Overflow direction always follows the sign of In1 for both ADD and SUB.
        if (error && is_arith(op)) begin
            result = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline (operand stage, result stage) with sticky {N,V,Z} flags.
// Build option ALU_SAT_EN (handled in alu_core) saturates ADD/SUB on overflow.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    opcode_e          s1_op;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_out;
    logic             s2_err;
    opcode_e          s2_op;

    logic [2:0]       flags_q;
    logic [WIDTH-1:0] core_out;
    logic             core_err;
    logic             s2_load;
    logic             s1_load;
    logic             out_fire;

    // Ready terms depend only on registered state and out_ready, never on in_valid.
    assign s2_load  = !s2_valid || bus.out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign out_fire = s2_valid && bus.out_ready;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op     (s1_op),
        .a      (s1_a),
        .b      (s1_b),
        .result (core_out),
        .error  (core_err)
    );

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (s1_load) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a  <= bus.ALU_In1;
                s1_b  <= bus.ALU_In2;
                s1_op <= opcode_e'(bus.Opcode);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_out   <= '0;
            s2_err   <= 1'b0;
            s2_op    <= OP_ADD;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_out <= core_out;
                s2_err <= core_err;
                s2_op  <= s1_op;
            end
        end
    end

    // Flags move only when a result is actually consumed; illegal beats leave them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else if (out_fire && (s2_op != OP_ILL)) begin
            flags_q[FLAG_Z] <= (s2_out == '0);
            flags_q[FLAG_N] <= s2_out[WIDTH-1];
            if (is_arith(s2_op)) begin
                flags_q[FLAG_V] <= s2_err;
            end
        end
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid;
    assign bus.ALU_Out   = s2_out;
    assign bus.Error     = s2_err;
    assign bus.Flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=16); expected beats are queued on acceptance and popped on output handshake.
`timescale 1ns/1ps
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 16;
    localparam longint MAXV = (longint'(1) <<< (W-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (W-1));

    typedef struct packed {
        logic [W-1:0] r;
        logic         e;
        logic [2:0]   op;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t ob[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   delivered = 0;
    logic [2:0] model_flags = 3'b000;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic exp_t ref_alu(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        exp_t x;
        longint sa, sb, s;
        int amt;
        logic [W-1:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        amt = int'(b) % W;
        t = a;
        x.op = op;
        x.e  = 1'b0;
        x.r  = '0;
        if (op == 3'd0 || op == 3'd1) begin
            s = (op == 3'd0) ? sa + sb : sa - sb;
            x.r = s[W-1:0];
            x.e = (s > MAXV) || (s < MINV);
`ifdef ALU_SAT_EN
            if (x.e) x.r = (s > 0) ? W'(MAXV) : W'(MINV);
`endif
        end else begin
            case (op)
                3'd2: x.r = a ^ b;
                3'd3: x.r = ~(a & b);
                3'd4: begin repeat (amt) t = {t[W-2:0], 1'b0};   x.r = t; end
                3'd5: begin repeat (amt) t = {t[W-1], t[W-1:1]}; x.r = t; end
                3'd6: begin repeat (amt) t = {t[0], t[W-1:1]};   x.r = t; end
                default: begin x.r = '0; x.e = 1'b1; end
            endcase
        end
        return x;
    endfunction

    function automatic logic [2:0] next_flags(logic [2:0] f, exp_t x);
        logic [2:0] n;
        n = f;
        if (x.op != 3'd7) begin
            n[FLAG_Z] = (x.r == '0);
            n[FLAG_N] = x.r[W-1];
            if (x.op == 3'd0 || x.op == 3'd1) n[FLAG_V] = x.e;
        end
        return n;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corners [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return W'($urandom);
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        exp_t x;
        if (rst) begin
            ob.delete();
            model_flags = 3'b000;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (ob.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got out=%h err=%b with no beat outstanding", bus.ALU_Out, bus.Error);
                end else begin
                    x = ob.pop_front();
                    if (bus.ALU_Out !== x.r || bus.Error !== x.e || bus.Flags !== model_flags) begin
                        n_err++;
                        $display("FAIL sb_result op=%0d: got out=%h err=%b flags=%b, want out=%h err=%b flags=%b",
                                 x.op, bus.ALU_Out, bus.Error, bus.Flags, x.r, x.e, model_flags);
                    end
                    model_flags = next_flags(model_flags, x);
                    delivered++;
                end
            end
            if (bus.in_valid && bus.in_ready)
                ob.push_back(ref_alu(bus.Opcode, bus.ALU_In1, bus.ALU_In2));
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.Opcode   = op;
        bus.ALU_In1  = a;
        bus.ALU_In2  = b;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready stayed 0, want 1");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.out_ready = 1'b1;
        while (ob.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (ob.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: %0d beats outstanding, want 0", ob.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.ALU_Out !== '0 || bus.Error !== 1'b0 || bus.Flags !== 3'b000) begin
            n_err++;
            $display("FAIL reset_state: got ov=%b out=%h err=%b flags=%b, want 0 0000 0 000",
                     bus.out_valid, bus.ALU_Out, bus.Error, bus.Flags);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b, want 1", bus.in_ready);
        end
    endtask

    task automatic test_add_overflow();
`ifdef ALU_SAT_EN
        logic [W-1:0] want_r = 16'h7FFF;
        logic [2:0]   want_f = 3'b010;
`else
        logic [W-1:0] want_r = 16'h8000;
        logic [2:0]   want_f = 3'b110;
`endif
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.Opcode   = 3'b000;
        bus.ALU_In1  = 16'h7FFF;
        bus.ALU_In2  = 16'h0001;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL add_accept: in_ready=%b, want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL add_latency_early: out_valid=%b one cycle after accept, want 0", bus.out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.ALU_Out !== want_r || bus.Error !== 1'b1) begin
            n_err++;
            $display("FAIL add_overflow: got ov=%b out=%h err=%b, want 1 %h 1",
                     bus.out_valid, bus.ALU_Out, bus.Error, want_r);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.Flags !== want_f) begin
            n_err++;
            $display("FAIL add_flags: got %b, want %b", bus.Flags, want_f);
        end
    endtask

    task automatic test_directed();
        logic [2:0]   t_op [6] = '{3'd1, 3'd1, 3'd5, 3'd7, 3'd6, 3'd4};
        logic [W-1:0] t_a  [6] = '{16'h8000, 16'h0005, 16'h8000, 16'h1234, 16'h8001, 16'h0001};
        logic [W-1:0] t_b  [6] = '{16'h0001, 16'h0005, 16'h0003, 16'h5678, 16'h0001, 16'h0013};
        logic         t_e  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef ALU_SAT_EN
        logic [W-1:0] t_r  [6] = '{16'h8000, 16'h0000, 16'hF000, 16'h0000, 16'hC000, 16'h0008};
        logic [2:0]   t_f  [6] = '{3'b110, 3'b001, 3'b100, 3'b100, 3'b100, 3'b000};
`else
        logic [W-1:0] t_r  [6] = '{16'h7FFF, 16'h0000, 16'hF000, 16'h0000, 16'hC000, 16'h0008};
        logic [2:0]   t_f  [6] = '{3'b010, 3'b001, 3'b100, 3'b100, 3'b100, 3'b000};
`endif
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int n = 0;
            send(t_op[i], t_a[i], t_b[i]);
            @(negedge clk);
            while (!bus.out_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.ALU_Out !== t_r[i] || bus.Error !== t_e[i]) begin
                n_err++;
                $display("FAIL directed_%0d op=%0d: got ov=%b out=%h err=%b, want 1 %h %b",
                         i, t_op[i], bus.out_valid, bus.ALU_Out, bus.Error, t_r[i], t_e[i]);
            end
            @(negedge clk);
            n_cmp++;
            if (bus.Flags !== t_f[i]) begin
                n_err++;
                $display("FAIL directed_flags_%0d op=%0d: got %b, want %b", i, t_op[i], bus.Flags, t_f[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   b_op [10];
        logic [W-1:0] b_a  [10];
        logic [W-1:0] b_b  [10];
        logic [W-1:0] held_out = '0;
        logic         held_err = 1'b0;
        bit           have_hold = 0;
        int           sent = 0;
        int           cyc = 0;
        int           d0 = delivered;
        for (int i = 0; i < 10; i++) begin
            b_op[i] = 3'($urandom_range(0, 6));
            b_a[i]  = pick_operand();
            b_b[i]  = pick_operand();
        end
        while (sent < 10 && cyc < 100) begin
            @(posedge clk); #1;
            bus.out_ready = !(cyc >= 3 && cyc < 8);
            bus.in_valid  = 1'b1;
            bus.Opcode    = b_op[sent];
            bus.ALU_In1   = b_a[sent];
            bus.ALU_In2   = b_b[sent];
            @(negedge clk);
            if (cyc < 3) begin
                n_cmp++;
                if (bus.in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_throughput cyc=%0d: in_ready=%b, want 1", cyc, bus.in_ready);
                end
            end
            if (!bus.out_ready) begin
                if (!have_hold) begin
                    held_out  = bus.ALU_Out;
                    held_err  = bus.Error;
                    have_hold = 1;
                end
                n_cmp++;
                if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                    bus.ALU_Out !== held_out || bus.Error !== held_err) begin
                    n_err++;
                    $display("FAIL b2b_stall cyc=%0d: got ov=%b ir=%b out=%h err=%b, want 1 0 %h %b",
                             cyc, bus.out_valid, bus.in_ready, bus.ALU_Out, bus.Error, held_out, held_err);
                end
            end
            if (bus.in_valid && bus.in_ready) sent++;
            cyc++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain();
        @(negedge clk);
        n_cmp++;
        if (sent != 10 || delivered - d0 != 10) begin
            n_err++;
            $display("FAIL b2b_count: sent=%0d delivered=%0d, want 10 10", sent, delivered - d0);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bus.out_ready = 1'b1;
        send(3'd0, 16'h8000, 16'h0000);
        drain();
        @(negedge clk);
        n_cmp++;
        if (bus.Flags !== 3'b100) begin
            n_err++;
            $display("FAIL rstmid_pre_flags: got %b, want 100", bus.Flags);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.Opcode = 3'd2; bus.ALU_In1 = 16'h00FF; bus.ALU_In2 = 16'h0F0F;
        @(posedge clk); #1;
        bus.Opcode = 3'd1; bus.ALU_In1 = 16'h0010; bus.ALU_In2 = 16'h0001;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_inflight: out_valid=%b before reset, want 1", bus.out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.Flags !== 3'b000 || bus.ALU_Out !== '0 || bus.Error !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_async: got ov=%b flags=%b out=%h err=%b, want 0 000 0000 0",
                     bus.out_valid, bus.Flags, bus.ALU_Out, bus.Error);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b1; bus.Opcode = 3'd0; bus.ALU_In1 = 16'h0003; bus.ALU_In2 = 16'h0004;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_ready: in_ready=%b after release, want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_latency_early: out_valid=%b, want 0", bus.out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.ALU_Out !== 16'h0007 || bus.Error !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_result: got ov=%b out=%h err=%b, want 1 0007 0",
                     bus.out_valid, bus.ALU_Out, bus.Error);
        end
        drain();
    endtask

    task automatic test_random();
        int sent = 0;
        int cyc = 0;
        int d0 = delivered;
        bit took = 0;
        bus.in_valid = 1'b0;
        while (sent < 400 && cyc < 5000) begin
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid || took) begin
                took = 0;
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.Opcode   = 3'($urandom_range(0, 7));
                bus.ALU_In1  = pick_operand();
                bus.ALU_In2  = pick_operand();
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                sent++;
                took = 1;
            end
            cyc++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain();
        @(negedge clk);
        n_cmp++;
        if (sent != 400 || delivered - d0 != 400) begin
            n_err++;
            $display("FAIL random_count: sent=%0d delivered=%0d, want 400 400", sent, delivered - d0);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.Opcode    = 3'd0;
        bus.ALU_In1   = '0;
        bus.ALU_In2   = '0;
        test_reset();
        test_add_overflow();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
